// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed transmit packet controller.
package usb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SYNC,
        PID,
        DATA,
        CRC_LO,
        CRC_HI,
        EOP,
        WAIT_EOP
    } state_type;

    typedef enum logic [1:0] {
        KIND_DATA  = 2'd0,
        KIND_ACK   = 2'd1,
        KIND_NAK   = 2'd2,
        KIND_STALL = 2'd3
    } tx_kind_type;

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'h80;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY    = 16'h8005;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            r[i] = v[15 - i];
        end
        return r;
    endfunction

    function automatic logic [7:0] pid_byte(input tx_kind_type kind, input logic tgl);
        logic [7:0] p;
        case (kind)
            KIND_ACK:   p = PID_ACK;
            KIND_NAK:   p = PID_NAK;
            KIND_STALL: p = PID_STALL;
            default:    p = tgl ? PID_DATA1 : PID_DATA0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/usb_tx_pkt_ctrl_if.sv
// Byte-stream link between the packet controller and the NRZI/bit-stuff serializer.
interface usb_tx_pkt_ctrl_if;

    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       eop_req;
    logic       eop_done;
    logic       tx_abort;

    modport master (
        output tx_byte,
        output tx_valid,
        output eop_req,
        output tx_abort,
        input  tx_ready,
        input  eop_done
    );

    modport slave (
        input  tx_byte,
        input  tx_valid,
        input  eop_req,
        input  tx_abort,
        output tx_ready,
        output eop_done
    );

endinterface

// File: rtl/usb_crc16_byte.sv
// One-byte step of the USB CRC16, processed LSB-first with the reflected polynomial.
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/usb_tx_pkt_ctrl.sv
// Sequences full-speed device-to-host handshake and DATA packets into the serializer,
// pulling payload from the endpoint FIFO and appending the in-line CRC16.
module usb_tx_pkt_ctrl
    import usb_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 64,
    parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1),
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [1:0]            tx_kind,
    input  logic                  data_tgl,
    input  logic [CNT_W-1:0]      tx_len,
    input  logic [7:0]            fifo_rdata,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    usb_tx_pkt_ctrl_if.master     ser,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  tx_err
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_type         state;
    state_type         state_nxt;
    tx_kind_type       kind_q;
    logic              tgl_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [15:0]       crc_q;
    logic [15:0]       crc_step;
    logic              aborted_q;
    logic              start_accept;

    usb_crc16_byte u_crc (
        .crc_in  (crc_q),
        .data    (fifo_rdata),
        .crc_out (crc_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            kind_q    <= KIND_DATA;
            tgl_q     <= 1'b0;
            cnt_q     <= '0;
            crc_q     <= CRC16_INIT;
            aborted_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_accept) begin
                kind_q    <= tx_kind_type'(tx_kind);
                tgl_q     <= data_tgl;
                cnt_q     <= (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
                crc_q     <= CRC16_INIT;
                aborted_q <= 1'b0;
            end
            if (fifo_rd) begin
                crc_q <= crc_step;
                cnt_q <= cnt_q - ONE;
            end
            if (ser.tx_abort) begin
                aborted_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        start_accept = 1'b0;
        ser.tx_byte  = '0;
        ser.tx_valid = 1'b0;
        ser.eop_req  = 1'b0;
        ser.tx_abort = 1'b0;
        fifo_rd      = 1'b0;
        tx_done      = 1'b0;
        tx_err       = 1'b0;
        busy         = (state != IDLE);

        case (state)
            IDLE: begin
                if (tx_start) begin
                    start_accept = 1'b1;
                    state_nxt    = SYNC;
                end
            end
            SYNC: begin
                ser.tx_byte  = SYNC_BYTE;
                ser.tx_valid = 1'b1;
                if (ser.tx_ready) state_nxt = PID;
            end
            PID: begin
                ser.tx_byte  = pid_byte(kind_q, tgl_q);
                ser.tx_valid = 1'b1;
                if (ser.tx_ready) begin
                    if (kind_q != KIND_DATA) state_nxt = EOP;
                    else if (cnt_q == '0)    state_nxt = CRC_LO;
                    else                     state_nxt = DATA;
                end
            end
            DATA: begin
                // FIFO empty while the serializer wants a byte is an underrun: abort, no CRC.
                ser.tx_byte  = fifo_rdata;
                ser.tx_valid = !fifo_empty;
                if (ser.tx_ready) begin
                    if (!fifo_empty) begin
                        fifo_rd = 1'b1;
                        if (cnt_q == ONE) state_nxt = CRC_LO;
                    end else begin
                        ser.tx_abort = 1'b1;
                        tx_err       = 1'b1;
                        state_nxt    = WAIT_EOP;
                    end
                end
            end
            CRC_LO: begin
                ser.tx_byte  = ~crc_q[7:0];
                ser.tx_valid = 1'b1;
                if (ser.tx_ready) state_nxt = CRC_HI;
            end
            CRC_HI: begin
                ser.tx_byte  = ~crc_q[15:8];
                ser.tx_valid = 1'b1;
                if (ser.tx_ready) state_nxt = EOP;
            end
            EOP: begin
                ser.eop_req = 1'b1;
                state_nxt   = WAIT_EOP;
            end
            WAIT_EOP: begin
                if (ser.eop_done) begin
                    tx_done   = !aborted_q;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Directed bench for usb_tx_pkt_ctrl with a packet-level byte-stream model and FIFO model.
module tb_usb_tx_pkt_ctrl;

    localparam int MAXB = 8;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_start = 1'b0;
    logic [1:0]    tx_kind = 2'd0;
    logic          data_tgl = 1'b0;
    logic [CW-1:0] tx_len = '0;
    logic [7:0]    fifo_rdata = 8'h00;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd;
    logic          busy;
    logic          tx_done;
    logic          tx_err;

    usb_tx_pkt_ctrl_if ser_if ();

    usb_tx_pkt_ctrl #(
        .MAX_BYTES (MAXB),
        .CNT_W     (CW),
        .SYNC_BYTE (8'h80)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .tx_kind    (tx_kind),
        .data_tgl   (data_tgl),
        .tx_len     (tx_len),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .ser        (ser_if.master),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    bit         exp_pl[$];
    logic [7:0] fifo_q[$];
    int         exp_rd;
    bit         exp_abort;

    int   n_rd, n_eop, n_done, n_abort, n_err;
    bit   pop_flag = 1'b0;
    bit   stalled = 1'b0;
    logic [7:0] held = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC: MSB-first register fed bit-reversed data, then reflected and complemented.
    function automatic logic [15:0] model_crc(input logic [7:0] d[$]);
        logic [15:0] r;
        logic [15:0] o;
        logic        fb;
        r = 16'hFFFF;
        foreach (d[j]) begin
            for (int i = 0; i < 8; i++) begin
                fb = r[15] ^ d[j][i];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h8005;
            end
        end
        for (int k = 0; k < 16; k++) o[k] = r[15 - k];
        return ~o;
    endfunction

    function automatic logic [7:0] pid_of(input int kind, input bit tgl);
        case (kind)
            1:       return 8'hD2;
            2:       return 8'h5A;
            3:       return 8'h1E;
            default: return tgl ? 8'h4B : 8'hC3;
        endcase
    endfunction

    task automatic fifo_upd();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic build_expect(input int kind, input bit tgl, input int len);
        logic [7:0] pl[$];
        logic [15:0] c;
        int eff;
        exp_q = {};
        exp_pl = {};
        pl = {};
        exp_rd = 0;
        exp_abort = 1'b0;
        exp_q.push_back(8'h80); exp_pl.push_back(1'b0);
        exp_q.push_back(pid_of(kind, tgl)); exp_pl.push_back(1'b0);
        if (kind == 0) begin
            eff = (len > MAXB) ? MAXB : len;
            for (int i = 0; i < eff && i < fifo_q.size(); i++) begin
                pl.push_back(fifo_q[i]);
                exp_q.push_back(fifo_q[i]); exp_pl.push_back(1'b1);
                exp_rd++;
            end
            if (fifo_q.size() < eff) begin
                exp_abort = 1'b1;
            end else begin
                c = model_crc(pl);
                exp_q.push_back(c[7:0]);  exp_pl.push_back(1'b0);
                exp_q.push_back(c[15:8]); exp_pl.push_back(1'b0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stalled  = 1'b0;
            pop_flag = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", ser_if.tx_valid, 1'b1);
                check("stall_byte", ser_if.tx_byte, held);
            end
            if (ser_if.tx_valid && ser_if.tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL extra_byte: got %0h expected no transfer", ser_if.tx_byte);
                end else begin
                    check("tx_byte", ser_if.tx_byte, exp_q.pop_front());
                    check("fifo_rd_xfer", fifo_rd, exp_pl.pop_front());
                end
            end else begin
                check("fifo_rd_noxfer", fifo_rd, 1'b0);
            end
            stalled  = ser_if.tx_valid && !ser_if.tx_ready;
            held     = ser_if.tx_byte;
            n_rd    += int'(fifo_rd);
            n_eop   += int'(ser_if.eop_req);
            n_done  += int'(tx_done);
            n_abort += int'(ser_if.tx_abort);
            n_err   += int'(tx_err);
            pop_flag = fifo_rd;
        end
    end

    task automatic clear_counts();
        n_rd = 0; n_eop = 0; n_done = 0; n_abort = 0; n_err = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pop_flag) begin
            void'(fifo_q.pop_front());
            pop_flag = 1'b0;
            fifo_upd();
        end
    endtask

    task automatic run_pkt(input int kind, input bit tgl, input int len, input int nfifo,
                           input logic [7:0] base, input bit bp, input bit glitch);
        int cyc;
        int after;
        bit seen_end;
        fifo_q = {};
        for (int i = 0; i < nfifo; i++) fifo_q.push_back(base + 8'(i));
        fifo_upd();
        build_expect(kind, tgl, len);
        clear_counts();
        step();
        tx_kind  = 2'(kind);
        data_tgl = tgl;
        tx_len   = CW'(len);
        tx_start = 1'b1;
        ser_if.tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc = 0; after = 0; seen_end = 1'b0;
        while (cyc < 400) begin
            step();
            cyc++;
            if (cyc == 1) begin
                check("busy_after_start", busy, 1'b1);
                check("valid_latency", ser_if.tx_valid, 1'b1);
            end
            tx_start = glitch && (cyc == 3);
            if (glitch && cyc == 3) tx_kind = 2'd1;
            ser_if.eop_done = glitch && (cyc == 4);
            if (!seen_end && (n_eop > 0 || n_abort > 0)) seen_end = 1'b1;
            if (seen_end) begin
                after++;
                if (after == 3) ser_if.eop_done = 1'b1;
                if (after == 5) break;
            end
            ser_if.tx_ready = (bp && !seen_end) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!seen_end) begin
            n_vec++;
            n_fail++;
            $display("FAIL packet_end_timeout: got no eop_req/tx_abort required one within 400 cycles");
        end
        check("leftover_bytes", exp_q.size(), 0);
        check("fifo_rd_count", n_rd, exp_rd);
        check("eop_req_count", n_eop, exp_abort ? 0 : 1);
        check("tx_done_count", n_done, exp_abort ? 0 : 1);
        check("tx_abort_count", n_abort, int'(exp_abort));
        check("tx_err_count", n_err, int'(exp_abort));
        check("busy_end", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] pin[$];
        int cyc;
        ser_if.tx_ready = 1'b1;
        ser_if.eop_done = 1'b0;

        pin = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_pin_check", model_crc(pin), 16'hB4C8);
        pin = {};
        check("model_pin_empty", model_crc(pin), 16'h0000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {ser_if.tx_valid, ser_if.tx_byte, ser_if.eop_req, ser_if.tx_abort,
                                fifo_rd, tx_done, tx_err}, '0);
        check("reset_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_pkt(1, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);   // ACK
        run_pkt(2, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);   // NAK
        run_pkt(3, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0);   // STALL
        run_pkt(0, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0);   // zero-length DATA1
        run_pkt(0, 1'b0, 4, 4, 8'h00, 1'b0, 1'b1);   // DATA0 00..03, stray start/eop_done
        run_pkt(0, 1'b1, 8, 8, 8'hA5, 1'b1, 1'b0);   // backpressure
        run_pkt(0, 1'b0, 12, 8, 8'hF0, 1'b0, 1'b0);  // length clamp
        run_pkt(0, 1'b0, 4, 2, 8'h10, 1'b0, 1'b0);   // underrun
        run_pkt(0, 1'b1, 1, 1, 8'h7E, 1'b0, 1'b0);   // recovery after underrun

        clear_counts();
        step();
        ser_if.eop_done = 1'b1;
        step();
        ser_if.eop_done = 1'b0;
        step();
        check("idle_eop_done_ignored", n_done, 0);
        check("idle_eop_done_busy", busy, 1'b0);

        fifo_q = {};
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h30 + 8'(i));
        fifo_upd();
        build_expect(0, 1'b0, 8);
        clear_counts();
        step();
        tx_kind = 2'd0; data_tgl = 1'b0; tx_len = CW'(8); tx_start = 1'b1;
        cyc = 0;
        while (n_rd < 2 && cyc < 50) begin
            step();
            tx_start = 1'b0;
            cyc++;
        end
        if (n_rd < 2) begin
            n_vec++;
            n_fail++;
            $display("FAIL reset_mid_timeout: got %0d payload reads required 2", n_rd);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_outputs", {ser_if.tx_valid, ser_if.tx_byte, ser_if.eop_req, ser_if.tx_abort,
                                   fifo_rd, tx_done, tx_err}, '0);
        check("midreset_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q = {};
        exp_pl = {};
        fifo_q = {};
        fifo_upd();

        run_pkt(1, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);   // ACK after reset

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
